// File: rtl/usram_pkg.sv
// Shared definitions for the uSRAM simple dual-port RAM model.
//   depth(aw)                   : number of words for an address width
//   init_word(init, dw, i)      : word i of a packed init vector, zero-extended
//                                 to MAX_DATA_WIDTH bits
//   read_latency(a_byp, d_byp)  : R_ADDR -> R_DATA latency in clock edges
package usram_pkg;

    localparam int MAX_DATA_WIDTH = 36;
    localparam int MAX_ADDR_WIDTH = 10;
    localparam int MAX_INIT_BITS  = MAX_DATA_WIDTH * (1 << MAX_ADDR_WIDTH);

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

    // The slice width varies with dw, so the word is gathered bit by bit.
    function automatic logic [MAX_DATA_WIDTH-1:0] init_word(
        input logic [MAX_INIT_BITS-1:0] init,
        input int                       dw,
        input int                       i
    );
        logic [MAX_DATA_WIDTH-1:0] w;
        w = '0;
        for (int b = 0; b < MAX_DATA_WIDTH; b++) begin
            if (b < dw) begin
                w[b] = init[i*dw + b];
            end
        end
        return w;
    endfunction

    // Each stage that is not bypassed adds one edge.
    function automatic int read_latency(input bit r_addr_bypass, input bit r_data_bypass);
        return (r_addr_bypass ? 0 : 1) + (r_data_bypass ? 0 : 1);
    endfunction

endpackage

// File: rtl/usram_sdp_model_if.sv
// Bus bundle for usram_sdp_model.
//   master : drives write port, read address and enables; receives read results
//   slave  : the RAM side
interface usram_sdp_model_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 6
);
    logic                  W_EN;
    logic [ADDR_WIDTH-1:0] W_ADDR;
    logic [DATA_WIDTH-1:0] W_DATA;
    logic                  BLK_EN;
    logic [ADDR_WIDTH-1:0] R_ADDR;
    logic                  R_ADDR_EN;
    logic                  R_DATA_EN;
    logic [DATA_WIDTH-1:0] R_DATA;
    logic                  R_VALID;
    logic                  COLLIDE;

    modport master (
        output W_EN, W_ADDR, W_DATA, BLK_EN, R_ADDR, R_ADDR_EN, R_DATA_EN,
        input  R_DATA, R_VALID, COLLIDE
    );

    modport slave (
        input  W_EN, W_ADDR, W_DATA, BLK_EN, R_ADDR, R_ADDR_EN, R_DATA_EN,
        output R_DATA, R_VALID, COLLIDE
    );
endinterface

// File: rtl/usram_pipe_reg.sv
// Enabled pipeline register with synchronous active-low clear.
//   CLK    : rising-edge clock
//   SRST_N : synchronous clear, active low (wins over EN)
//   EN     : load enable
//   D / Q  : data in / registered data out
module usram_pipe_reg #(
    parameter int WIDTH = 13
) (
    input  logic             CLK,
    input  logic             SRST_N,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);
    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge CLK) begin
        if (!SRST_N) begin
            q_reg <= '0;
        end else if (EN) begin
            q_reg <= D;
        end
    end

    assign Q = q_reg;
endmodule

// File: rtl/usram_sdp_model.sv
// Behavioural model of a uSRAM-style simple dual-port RAM.
// One synchronous write port, one combinational array read with optional
// address and data register stages, read-valid tracking and a registered
// read/write collision flag.
//   CLK    : single rising-edge clock
//   SRST_N : synchronous active-low reset; clears pipeline/flag registers,
//            never the array
//   bus    : W_EN/W_ADDR/W_DATA write port, BLK_EN/R_ADDR/R_ADDR_EN/R_DATA_EN
//            read controls, R_DATA/R_VALID/COLLIDE results
module usram_sdp_model
    import usram_pkg::*;
#(
    parameter int DATA_WIDTH    = 12,
    parameter int ADDR_WIDTH    = 6,
    parameter bit R_ADDR_BYPASS = 1'b1,
    parameter bit R_DATA_BYPASS = 1'b1,
    parameter logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0] INIT = '0
) (
    input  logic             CLK,
    input  logic             SRST_N,
    usram_sdp_model_if.slave bus
);
    localparam int DEPTH = depth(ADDR_WIDTH);

    // Packed word array so INIT maps straight onto it: word i = INIT[i*DW +: DW].
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_reg = INIT;

    logic [ADDR_WIDTH-1:0] ea;        // effective read address
    logic                  av;        // address-stage validity
    logic [DATA_WIDTH-1:0] arr;       // raw array output
    logic [DATA_WIDTH-1:0] rd_word;   // array output gated by validity
    logic                  collide_reg;

    // Enables of bypassed stages are intentionally ignored.
    wire unused_ok = &{1'b0, bus.R_ADDR_EN, bus.R_DATA_EN};

    // Write port. An unknown enable poisons the addressed word; an unknown
    // address poisons the whole array, since any word might have been hit.
    // In two-state evaluation the unknown checks are constant false.
    always_ff @(posedge CLK) begin
        if ($isunknown(bus.W_EN)) begin
            if ($isunknown(bus.W_ADDR)) begin
                mem_reg <= 'x;
            end else begin
                mem_reg[bus.W_ADDR] <= 'x;
            end
        end else if (bus.W_EN) begin
            if ($isunknown(bus.W_ADDR)) begin
                mem_reg <= 'x;
            end else begin
                mem_reg[bus.W_ADDR] <= bus.W_DATA;
            end
        end
    end

    // Address stage.
    if (R_ADDR_BYPASS) begin : g_addr_byp
        assign ea = bus.R_ADDR;
        assign av = bus.BLK_EN;
    end else begin : g_addr_reg
        logic [ADDR_WIDTH:0] addr_q;
        usram_pipe_reg #(.WIDTH(ADDR_WIDTH + 1)) u_addr_reg (
            .CLK    (CLK),
            .SRST_N (SRST_N),
            .EN     (bus.R_ADDR_EN),
            .D      ({bus.BLK_EN, bus.R_ADDR}),
            .Q      (addr_q)
        );
        assign {av, ea} = addr_q;
    end

    // The array read sees the post-edge contents; there is no bypass of a
    // write that is still pending at the same edge.
    assign arr     = mem_reg[ea];
    assign rd_word = av ? arr : '0;

    // Data stage.
    if (R_DATA_BYPASS) begin : g_data_byp
        assign bus.R_DATA  = rd_word;
        assign bus.R_VALID = av;
    end else begin : g_data_reg
        logic [DATA_WIDTH:0] data_q;
        usram_pipe_reg #(.WIDTH(DATA_WIDTH + 1)) u_data_reg (
            .CLK    (CLK),
            .SRST_N (SRST_N),
            .EN     (bus.R_DATA_EN),
            .D      ({av, rd_word}),
            .Q      (data_q)
        );
        assign {bus.R_VALID, bus.R_DATA} = data_q;
    end

    // Flags that the edge just taken wrote the word currently being read, so
    // R_DATA sampled now may hold newer data than the pre-write contents.
    always_ff @(posedge CLK) begin
        if (!SRST_N) begin
            collide_reg <= 1'b0;
        end else begin
            collide_reg <= bus.W_EN & av & (bus.W_ADDR == ea);
        end
    end

    assign bus.COLLIDE = collide_reg;
endmodule

// File: tb/tb_usram_sdp_model.sv
// Directed bench for usram_sdp_model across four parameter sets:
//   u0 : 12x64, both stages bypassed, INIT word 5 = 0xABC
//   u1 : 12x64, both stages registered, INIT all zero
//   u2 : 12x64, address bypassed, data registered, INIT word 7 = 0x0FF
//   u3 : 36x1024, both bypassed, INIT word 0 / word 1023 non-zero
// Expected reads are queued when stimulus is applied and compared when the
// read result is due.
module tb_usram_sdp_model;
    import usram_pkg::*;

    localparam int W3 = 36 * 1024;
    localparam logic [12*64-1:0] INIT0 = {{(58*12){1'b0}}, 12'hABC, {(5*12){1'b0}}};
    localparam logic [12*64-1:0] INIT2 = {{(56*12){1'b0}}, 12'h0FF, {(7*12){1'b0}}};
    localparam logic [W3-1:0]    INIT3 = {36'h5_5555_5555, {(1022*36){1'b0}}, 36'h0_ABCD_1234};

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    usram_sdp_model_if #(.DATA_WIDTH(12), .ADDR_WIDTH(6))  if0 ();
    usram_sdp_model_if #(.DATA_WIDTH(12), .ADDR_WIDTH(6))  if1 ();
    usram_sdp_model_if #(.DATA_WIDTH(12), .ADDR_WIDTH(6))  if2 ();
    usram_sdp_model_if #(.DATA_WIDTH(36), .ADDR_WIDTH(10)) if3 ();

    usram_sdp_model #(.DATA_WIDTH(12), .ADDR_WIDTH(6), .R_ADDR_BYPASS(1'b1),
                      .R_DATA_BYPASS(1'b1), .INIT(INIT0))
        u0 (.CLK(clk), .SRST_N(rst_n), .bus(if0));
    usram_sdp_model #(.DATA_WIDTH(12), .ADDR_WIDTH(6), .R_ADDR_BYPASS(1'b0),
                      .R_DATA_BYPASS(1'b0), .INIT('0))
        u1 (.CLK(clk), .SRST_N(rst_n), .bus(if1));
    usram_sdp_model #(.DATA_WIDTH(12), .ADDR_WIDTH(6), .R_ADDR_BYPASS(1'b1),
                      .R_DATA_BYPASS(1'b0), .INIT(INIT2))
        u2 (.CLK(clk), .SRST_N(rst_n), .bus(if2));
    usram_sdp_model #(.DATA_WIDTH(36), .ADDR_WIDTH(10), .R_ADDR_BYPASS(1'b1),
                      .R_DATA_BYPASS(1'b1), .INIT(INIT3))
        u3 (.CLK(clk), .SRST_N(rst_n), .bus(if3));

    int n_errors = 0;
    int n_checks = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input logic [63:0] got);
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    // Drive and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if0.W_EN = 0; if0.W_ADDR = '0; if0.W_DATA = '0; if0.BLK_EN = 0;
        if0.R_ADDR = '0; if0.R_ADDR_EN = 0; if0.R_DATA_EN = 0;
        if1.W_EN = 0; if1.W_ADDR = '0; if1.W_DATA = '0; if1.BLK_EN = 0;
        if1.R_ADDR = '0; if1.R_ADDR_EN = 0; if1.R_DATA_EN = 0;
        if2.W_EN = 0; if2.W_ADDR = '0; if2.W_DATA = '0; if2.BLK_EN = 0;
        if2.R_ADDR = '0; if2.R_ADDR_EN = 0; if2.R_DATA_EN = 0;
        if3.W_EN = 0; if3.W_ADDR = '0; if3.W_DATA = '0; if3.BLK_EN = 0;
        if3.R_ADDR = '0; if3.R_ADDR_EN = 0; if3.R_DATA_EN = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        tick();
        tick();

        // ---- reset state ----
        check("rst_u1_rd",  {if1.R_VALID, if1.R_DATA}, 64'h0);
        check("rst_u1_col", if1.COLLIDE, 64'h0);
        check("rst_u2_rd",  {if2.R_VALID, if2.R_DATA}, 64'h0);
        check("rst_u2_col", if2.COLLIDE, 64'h0);
        check("rst_u0_rd",  {if0.R_VALID, if0.R_DATA}, 64'h0);
        rst_n = 1'b1;
        tick();

        // ---- u0: fully bypassed, same-cycle read ----
        if0.BLK_EN = 1; if0.R_ADDR = 6'd5; #1;
        sb_push("u0_init5", {1'b1, 12'hABC});
        sb_pop_check({if0.R_VALID, if0.R_DATA});
        if0.BLK_EN = 0; #1;
        sb_push("u0_blk_off", 64'h0);
        sb_pop_check({if0.R_VALID, if0.R_DATA});
        // write and read the same word: old value before the edge, new after
        if0.BLK_EN = 1; if0.R_ADDR = 6'd9;
        if0.W_EN = 1; if0.W_ADDR = 6'd9; if0.W_DATA = 12'h3C3; #1;
        sb_push("u0_pre_write", {1'b1, 12'h000});
        sb_pop_check({if0.R_VALID, if0.R_DATA});
        tick();
        if0.W_EN = 0;
        check("u0_collide", if0.COLLIDE, 64'h1);
        sb_push("u0_post_write", {1'b1, 12'h3C3});
        sb_pop_check({if0.R_VALID, if0.R_DATA});
        tick();
        check("u0_collide_clr", if0.COLLIDE, 64'h0);
        if0.BLK_EN = 0;

        // ---- u1: both registered, two-edge latency ----
        if1.W_EN = 1; if1.W_ADDR = 6'd3; if1.W_DATA = 12'h123;
        tick();
        if1.W_EN = 0;
        if1.R_ADDR = 6'd3; if1.R_ADDR_EN = 1; if1.R_DATA_EN = 1; if1.BLK_EN = 1;
        sb_push("u1_lat2", {1'b1, 12'h123});
        tick();
        check("u1_lat1_not_valid", {if1.R_VALID, if1.R_DATA}, 64'h0);
        tick();
        sb_pop_check({if1.R_VALID, if1.R_DATA});
        if1.R_ADDR_EN = 0; if1.R_DATA_EN = 0; if1.R_ADDR = '0; if1.BLK_EN = 0;
        tick();
        tick();
        check("u1_hold", {if1.R_VALID, if1.R_DATA}, {1'b1, 12'h123});

        // ---- u1: held address re-sampled after an intervening write ----
        if1.R_ADDR = 6'd4; if1.R_ADDR_EN = 1; if1.BLK_EN = 1;
        tick();
        if1.R_ADDR_EN = 0; if1.R_ADDR = '0; if1.BLK_EN = 0;
        if1.W_EN = 1; if1.W_ADDR = 6'd4; if1.W_DATA = 12'h9A5;
        tick();
        if1.W_EN = 0;
        check("u1_hold_collide", if1.COLLIDE, 64'h1);
        check("u1_data_held", {if1.R_VALID, if1.R_DATA}, {1'b1, 12'h123});
        if1.R_DATA_EN = 1;
        sb_push("u1_resample", {1'b1, 12'h9A5});
        tick();
        if1.R_DATA_EN = 0;
        sb_pop_check({if1.R_VALID, if1.R_DATA});

        // ---- u1: reset mid-read, write at the reset edge is kept ----
        if1.R_ADDR = 6'd2; if1.R_ADDR_EN = 1; if1.R_DATA_EN = 1; if1.BLK_EN = 1;
        tick();
        rst_n = 0;
        if1.W_EN = 1; if1.W_ADDR = 6'd2; if1.W_DATA = 12'h777;
        tick();
        rst_n = 1;
        if1.W_EN = 0;
        check("u1_rst_rd",  {if1.R_VALID, if1.R_DATA}, 64'h0);
        check("u1_rst_col", if1.COLLIDE, 64'h0);
        sb_push("u1_after_rst", {1'b1, 12'h777});
        tick();
        tick();
        sb_pop_check({if1.R_VALID, if1.R_DATA});
        if1.R_ADDR_EN = 0; if1.R_DATA_EN = 0; if1.BLK_EN = 0;

        // ---- u2: collision with registered data ----
        if2.W_EN = 1; if2.W_ADDR = 6'd7; if2.W_DATA = 12'h055;
        if2.R_ADDR = 6'd7; if2.BLK_EN = 1; if2.R_DATA_EN = 1;
        sb_push("u2_pre_edge_val", {1'b1, 12'h0FF});
        tick();
        if2.W_EN = 0;
        check("u2_collide", if2.COLLIDE, 64'h1);
        sb_pop_check({if2.R_VALID, if2.R_DATA});
        sb_push("u2_new_val", {1'b1, 12'h055});
        tick();
        check("u2_collide_clr", if2.COLLIDE, 64'h0);
        sb_pop_check({if2.R_VALID, if2.R_DATA});
        if2.W_EN = 1; if2.W_ADDR = 6'd8; if2.W_DATA = 12'h111;
        tick();
        if2.W_EN = 0;
        check("u2_no_collide_diff_addr", if2.COLLIDE, 64'h0);
        if2.R_DATA_EN = 0; if2.BLK_EN = 0;
        tick();
        check("u2_data_hold", {if2.R_VALID, if2.R_DATA}, {1'b1, 12'h055});

        // ---- u3: 36-bit x 1024 sweep ----
        if3.BLK_EN = 1; if3.R_ADDR = 10'd1023;
        if3.W_EN = 1; if3.W_ADDR = 10'd1023; if3.W_DATA = 36'hF_0000_0001; #1;
        sb_push("u3_init1023", {1'b1, init_word(INIT3, 36, 1023)});
        sb_pop_check({if3.R_VALID, if3.R_DATA});
        tick();
        if3.W_EN = 0;
        check("u3_collide", if3.COLLIDE, 64'h1);
        sb_push("u3_rd1023", {1'b1, 36'hF_0000_0001});
        sb_pop_check({if3.R_VALID, if3.R_DATA});
        if3.R_ADDR = 10'd0; #1;
        sb_push("u3_rd0_init", {1'b1, 36'h0_ABCD_1234});
        sb_pop_check({if3.R_VALID, if3.R_DATA});
        if3.BLK_EN = 0; #1;
        sb_push("u3_blk_off", 64'h0);
        sb_pop_check({if3.R_VALID, if3.R_DATA});

        check("sb_leftover", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/usram_sdp_model.md
Name: usram_sdp_model

Overview:
- Parametrised behavioural simulation model of a PolarFire uSRAM-style simple dual-port RAM. It is the generalised, simulatable successor to the fixed 64x12 blackbox.
- Provides one synchronous write port and one asynchronous-array read port.
- Read address and read data each have an optional register stage, giving a configurable pipeline.
- Adds read-valid tracking and read/write collision flagging.
- Sits in the cell simulation library; used by techmap-verified designs and by equivalence checks after memory inference.

Parameters:
- DATA_WIDTH, 12, width of each word (1..36).
- ADDR_WIDTH, 6, address bits; depth = 2**ADDR_WIDTH (2..10).
- R_ADDR_BYPASS, 1, 1 = read address used directly; 0 = read address registered.
- R_DATA_BYPASS, 1, 1 = array output drives R_DATA directly; 0 = read data registered.
- INIT, all-zero, DATA_WIDTH*2**ADDR_WIDTH initial array contents; word i = INIT[i*DATA_WIDTH +: DATA_WIDTH].

Ports:
- CLK  input  1  single clock for all registers; rising edge.
- SRST_N  input  1  synchronous, active-low reset; clears pipeline registers only, never the array.
- W_EN  input  1  write enable.
- W_ADDR  input  ADDR_WIDTH  write address.
- W_DATA  input  DATA_WIDTH  write data.
- BLK_EN  input  1  read block enable.
- R_ADDR  input  ADDR_WIDTH  read address.
- R_ADDR_EN  input  1  load enable for the address register; ignored when R_ADDR_BYPASS=1.
- R_DATA_EN  input  1  load enable for the data register; ignored when R_DATA_BYPASS=1.
- R_DATA  output  DATA_WIDTH  read data.
- R_VALID  output  1  R_DATA carries the result of an enabled read.
- COLLIDE  output  1  registered flag: the previous edge wrote the address being read.

Behaviour:
- Clock and reset: one clock, CLK; reset is synchronous and active-low, SRST_N. Reset is sampled only at the CLK rising edge.
- Write: at the rising edge with W_EN=1, mem[W_ADDR] <= W_DATA. Writes are unaffected by SRST_N and BLK_EN.
- Effective address: ea = R_ADDR_BYPASS ? R_ADDR : addr_q.
- Address register (R_ADDR_BYPASS=0):
  - SRST_N=0 -> addr_q <= 0 and av_q <= 0.
  - Else if R_ADDR_EN -> addr_q <= R_ADDR and av_q <= BLK_EN.
  - Else hold both.
- Address-stage validity: av = R_ADDR_BYPASS ? BLK_EN : av_q.
- Array read: combinational, arr = mem[ea]. A write at an edge is visible on arr immediately after that edge (write-before-read across the edge; no same-cycle bypass).
- Data stage, R_DATA_BYPASS=1:
  - R_DATA = av ? arr : 0.
  - R_VALID = av.
- Data stage, R_DATA_BYPASS=0:
  - SRST_N=0 -> data_q <= 0 and dv_q <= 0.
  - Else if R_DATA_EN -> data_q <= av ? arr : 0 and dv_q <= av.
  - Else hold both.
  - R_DATA = data_q; R_VALID = dv_q.
- Latency from R_ADDR to R_DATA (edges): 0 when both bypassed; 1 with one stage registered; 2 with both registered.
- COLLIDE:
  - SRST_N=0 -> 0.
  - Else COLLIDE <= W_EN & av & (W_ADDR == ea), sampled at the same edge as the write.
  - It marks that R_DATA, when sampled this cycle, reflects data newer than the pre-write contents.
- Reset values: R_DATA = 0, R_VALID = 0, COLLIDE = 0 in every registered configuration. In the fully bypassed configuration R_DATA and R_VALID follow BLK_EN combinationally.
- Reset mid-operation: a reset during an in-flight read drops it; R_VALID is 0 the next cycle. An edge with a write and a reset still performs the write.
- Simultaneous R_ADDR_EN=0 and R_DATA_EN=1: the data register re-samples the held address, so R_DATA reflects any intervening write.
- Address wrap: addresses are taken modulo 2**ADDR_WIDTH by width. No out-of-range case exists.
- X handling: W_EN=X corrupts mem[W_ADDR] to X. An address containing X corrupts the entire array on write, and reads return X.

Decomposition:
- Shared package usram_pkg:
  - localparam functions depth(ADDR_WIDTH) and init_word(INIT, i).
  - Latency constant computed from the two bypass parameters.
- One sub-module is natural: usram_pipe_reg, a DATA_WIDTH+1-bit register with synchronous active-low clear and enable. It is instantiated via generate for the address stage (data = address + valid) and the data stage (data = word + valid).
- The array and the collision logic stay in the top module.

Test Plan:
- Both bypassed, INIT word 5 = 12'hABC: BLK_EN=1, R_ADDR=5 -> R_DATA=12'hABC and R_VALID=1 in the same cycle. BLK_EN=0 -> R_DATA=0 and R_VALID=0.
- Both registered: write 12'h123 to address 3, then R_ADDR=3 with R_ADDR_EN=R_DATA_EN=BLK_EN=1 -> R_DATA=12'h123 and R_VALID=1 exactly 2 edges after the address is applied. R_DATA holds when both enables drop.
- Collision, R_ADDR_BYPASS=1, R_DATA_BYPASS=0: W_EN=1, W_ADDR=R_ADDR=7, W_DATA=12'h055, old mem[7]=12'h0FF -> next cycle COLLIDE=1 and data_q=12'h0FF (the pre-edge value). One cycle later, with R_DATA_EN=1, R_DATA=12'h055.
- Reset mid-read, both registered: after loading address 2, assert SRST_N=0 for 1 edge -> R_DATA=0, R_VALID=0, COLLIDE=0. A simultaneous write to address 2 of 12'h777 is retained and is read back as 12'h777 afterwards.
- Parameter sweep DATA_WIDTH=36, ADDR_WIDTH=10: write 36'hF_0000_0001 to address 1023, then read 1023 and 0 -> values 36'hF_0000_0001 and INIT word 0 respectively.
- Hold behaviour, R_ADDR_BYPASS=0: R_ADDR_EN=0 with addr_q=4, then write 12'h9A5 to address 4 and pulse R_DATA_EN -> R_DATA=12'h9A5.
